// File: rtl/shift_feed_ctrl_pkg.sv
// Shared types for the window shift-register feeder.
//   state_e      : feeder FSM states.
//   fifo_entry_t : one buffered stream element {last, data} at the default
//                  8-bit element width.
package shift_feed_pkg;

  localparam int unsigned FEED_DATA_W = 8;

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    WAIT_WIN = 2'd1,
    FINAL    = 2'd2
  } state_e;

  typedef struct packed {
    logic                   last;
    logic [FEED_DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/shift_feed_ctrl_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through read port.
//   clk, rst       : clock, asynchronous active-high reset.
//   push/push_data : write strobe and data (caller keeps push low when full).
//   pop            : consume the head entry (ignored when empty).
//   pop_data       : current head entry, valid while !empty.
//   full/empty     : occupancy flags, from registered pointers only.
module sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/shift_feed_ctrl.sv
// Feeder for the WIN-element window shift register.
//   in_data/in_valid/in_last/in_ready : input byte stream (valid/ready).
//   shift_data/shift                  : element and shift enable to the register.
//   final_output                      : selects final-byte presentation.
//   win_valid/win_ready               : window (or final byte) handshake to
//                                       the downstream consumer.
// Elements are buffered in a FIFO; the FSM shifts WIN elements for the first
// window of a stream and STRIDE for each later one, then waits for win_ready.
// A stream's last element leads to one final presentation.
module shift_feed_ctrl
  import shift_feed_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned WIN        = 4,
  parameter int unsigned STRIDE     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] shift_data,
  output logic              shift,
  output logic              final_output,
  output logic              win_valid,
  input  logic              win_ready
);

  localparam int unsigned CW = $clog2(WIN + 1);

  logic [DATA_W:0] fifo_head;
  logic            fifo_full, fifo_empty;
  logic            head_last;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            first_done_q, first_done_d;
  logic            pending_final_q, pending_final_d;
  logic [CW-1:0]   cnt_inc, target;

  sync_fifo #(
    .WIDTH(DATA_W + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (in_valid && !fifo_full),
    .push_data({in_last, in_data}),
    .pop      (shift),
    .pop_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign in_ready   = !fifo_full;
  assign head_last  = fifo_head[DATA_W];
  assign shift_data = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
  assign cnt_inc    = cnt_q + CW'(1);
  assign target     = first_done_q ? CW'(STRIDE) : CW'(WIN);

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    first_done_d    = first_done_q;
    pending_final_d = pending_final_q;
    shift           = 1'b0;
    final_output    = 1'b0;
    win_valid       = 1'b0;
    case (state_q)
      FILL: begin
        shift = !fifo_empty;
        if (shift) begin
          if (head_last) pending_final_d = 1'b1;
          if (cnt_inc == target) begin
            cnt_d   = '0;
            state_d = WAIT_WIN;
          end else begin
            cnt_d = cnt_inc;
            // last before the window completes: drop the partial window
            if (head_last) state_d = FINAL;
          end
        end
      end
      WAIT_WIN: begin
        win_valid = 1'b1;
        if (win_ready) begin
          first_done_d = 1'b1;
          state_d      = pending_final_q ? FINAL : FILL;
        end
      end
      FINAL: begin
        win_valid    = 1'b1;
        final_output = 1'b1;
        if (win_ready) begin
          cnt_d           = '0;
          first_done_d    = 1'b0;
          pending_final_d = 1'b0;
          state_d         = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= FILL;
      cnt_q           <= '0;
      first_done_q    <= 1'b0;
      pending_final_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      first_done_q    <= first_done_d;
      pending_final_q <= pending_final_d;
    end
  end

endmodule

// File: tb/tb_shift_feed_ctrl.sv
// Randomized bench for shift_feed_ctrl against a queue-level model:
// the model holds the buffered elements and the list of pending window/final
// presentations, derived from each stream's element index.
module tb_shift_feed_ctrl;
  import shift_feed_pkg::*;

  localparam int unsigned DW     = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned WIN    = 4;
  localparam int unsigned STRIDE = 1;

  logic          clk, rst;
  logic [DW-1:0] in_data;
  logic          in_valid, in_last, in_ready;
  logic [DW-1:0] shift_data;
  logic          shift, final_output, win_valid, win_ready;

  shift_feed_ctrl #(
    .DATA_W    (DW),
    .FIFO_DEPTH(DEPTH),
    .WIN       (WIN),
    .STRIDE    (STRIDE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_ready    (in_ready),
    .shift_data  (shift_data),
    .shift       (shift),
    .final_output(final_output),
    .win_valid   (win_valid),
    .win_ready   (win_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  fifo_entry_t mq[$];   // elements buffered in the feeder
  bit          ev[$];   // pending presentations: 0 = window, 1 = final
  fifo_entry_t src[$];  // elements still to be offered
  int unsigned stream_k = 0;
  int          dut_win = 0;
  int          dut_fin = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_val("in_ready",     32'(in_ready),     32'(mq.size() < DEPTH));
    check_val("shift",        32'(shift),        32'(ev.size() == 0 && mq.size() > 0));
    check_val("win_valid",    32'(win_valid),    32'(ev.size() > 0));
    check_val("final_output", 32'(final_output), 32'(ev.size() > 0 && ev[0]));
    check_val("shift_data",   32'(shift_data),   mq.size() > 0 ? 32'(mq[0].data) : 32'd0);
  endtask

  // Advance the model across the coming rising edge.
  task automatic model_step();
    bit          rdy, shf;
    fifo_entry_t e;
    rdy = mq.size() < DEPTH;
    shf = ev.size() == 0 && mq.size() > 0;
    if (ev.size() > 0 && win_ready) void'(ev.pop_front());
    if (shf) begin
      e = mq.pop_front();
      stream_k++;
      if (stream_k >= WIN && (stream_k - WIN) % STRIDE == 0) ev.push_back(1'b0);
      if (e.last) begin
        ev.push_back(1'b1);
        stream_k = 0;
      end
    end
    if (in_valid && rdy) begin
      e.last = in_last;
      e.data = in_data;
      mq.push_back(e);
      void'(src.pop_front());
    end
  endtask

  task automatic run(input int n, input int pv, input int pr);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_outputs();
      in_valid  = src.size() > 0 && $urandom_range(99) < pv;
      in_data   = in_valid ? src[0].data : DW'($urandom);
      in_last   = in_valid ? src[0].last : 1'($urandom);
      win_ready = $urandom_range(99) < pr;
      if (win_valid && win_ready) begin
        if (final_output) dut_fin++;
        else dut_win++;
      end
      model_step();
    end
  endtask

  task automatic add(input logic [DW-1:0] d, input logic l);
    fifo_entry_t e;
    e.data = d;
    e.last = l;
    src.push_back(e);
  endtask

  task automatic add_rand_stream(input int len);
    for (int i = 0; i < len; i++) add(DW'($urandom), i == len - 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    mq.delete();
    ev.delete();
    src.delete();
    stream_k = 0;
    check_outputs();
    in_valid  = 1'b0;
    win_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_data = '0;
    win_ready = 1'b0;
    #2;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;

    // four bytes, last on the fourth: one window then one final
    add(8'h11, 0); add(8'h22, 0); add(8'h33, 0); add(8'h44, 1);
    dut_win = 0; dut_fin = 0;
    run(12, 100, 100);
    check_val("t1_windows", 32'(dut_win), 32'd1);
    check_val("t1_finals",  32'(dut_fin), 32'd1);

    // 1..6, stride 1: windows after 4, 5 and 6, then final
    for (int i = 1; i <= 6; i++) add(DW'(i), i == 6);
    dut_win = 0; dut_fin = 0;
    run(16, 100, 100);
    check_val("t2_windows", 32'(dut_win), 32'd3);
    check_val("t2_finals",  32'(dut_fin), 32'd1);

    // consumer stalls with more bytes offered
    for (int i = 0; i < 12; i++) add(DW'(8'hC0 + i), i == 11);
    run(16, 100, 0);
    run(40, 100, 100);

    // last on the 2nd element: no window, only final
    add(8'hAA, 0); add(8'hBB, 1);
    dut_win = 0; dut_fin = 0;
    run(8, 100, 0);
    run(4, 100, 100);
    check_val("t4_windows", 32'(dut_win), 32'd0);
    check_val("t4_finals",  32'(dut_fin), 32'd1);

    // reset while a window waits with entries buffered
    for (int i = 0; i < 7; i++) add(DW'(8'h50 + i), 1'b0);
    run(14, 100, 0);
    do_reset();
    for (int i = 1; i <= 4; i++) add(DW'(i), i == 4);
    dut_win = 0; dut_fin = 0;
    run(12, 100, 100);
    check_val("t5_windows", 32'(dut_win), 32'd1);
    check_val("t5_finals",  32'(dut_fin), 32'd1);

    // full-rate back-to-back stream
    add_rand_stream(40);
    run(100, 100, 100);

    // random streams, handshake rates and occasional resets
    for (int i = 0; i < 40; i++) begin
      add_rand_stream($urandom_range(1, 10));
      run($urandom_range(5, 40), $urandom_range(20, 100), $urandom_range(10, 100));
      if (i % 13 == 7) do_reset();
    end
    run(120, 100, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
